// File: rtl/multi_cycle_mem_responder_pkg.sv
// Shared types and address helpers for the multi-cycle memory responder.
// The same helpers are used by the responder and by its scoreboard.
package mem_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Nonzero when the byte address is misaligned or lies above the stored range.
    function automatic logic addr_error(input logic [63:0] addr, input int idx_w);
        logic [63:0] hi;
        hi = addr >> (idx_w + 2);
        return (addr[1:0] != 2'b00) || (hi != 64'd0);
    endfunction

    function automatic logic [63:0] word_index(input logic [63:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/multi_cycle_mem_responder_if.sv
// Request/response bus between the multi-cycle controller and the memory responder.
interface multi_cycle_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );
endinterface

// File: rtl/multi_cycle_mem_responder_wait_counter.sv
// 4-bit loadable down-counter timing the wait states; last flags count==1.
module mem_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    input  logic [3:0] load_value,
    output logic       last
);
    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == 4'd1);
endmodule

// File: rtl/multi_cycle_mem_responder.sv
// Word-addressed instruction/data store answering one request at a time
// with a single-cycle response after WAIT_CYCLES wait states.
module multi_cycle_mem_responder
    import mem_rsp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    multi_cycle_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t                state_q, state_d;
    logic                  req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q, busy_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  cur_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_err;
    logic                  accept;
    logic                  commit;
    logic                  mem_we;
    logic                  cnt_last;

    // Not cleared by reset; zero at elaboration.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .enable     (state_q == WAIT),
        .load_value (4'(WAIT_CYCLES)),
        .last       (cnt_last)
    );

    // With zero wait states RESPOND is entered on the accepting edge, before
    // the request registers hold the request, so the port values are used then.
    always_comb begin
        cur_write = (state_q == IDLE) ? bus.req_write : req_write_q;
        cur_addr  = (state_q == IDLE) ? bus.req_addr  : req_addr_q;
        cur_wdata = (state_q == IDLE) ? bus.req_wdata : req_wdata_q;
        cur_idx   = cur_addr[IDX_W+1:2];
        cur_err   = addr_error(64'(cur_addr), IDX_W);
    end

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        accept      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept      = 1'b1;
                    req_write_d = bus.req_write;
                    req_addr_d  = bus.req_addr;
                    req_wdata_d = bus.req_wdata;
                    state_d     = (WAIT_CYCLES == 0) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                if (cnt_last) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Store commit and read capture share the edge that enters RESPOND.
        if (state_d == RESPOND) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = cur_err;
            rsp_rdata_d = (cur_err || cur_write) ? '0 : mem_q[cur_idx];
            commit      = cur_write && !cur_err;
        end

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign mem_we = commit && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_multi_cycle_mem_responder.sv
// Directed scoreboard bench: one responder with two wait states, one with none.
module tb_multi_cycle_mem_responder;
    import mem_rsp_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        sb_q[$];
    logic [31:0] model_mem [2][64];
    logic        b_wr   [4];
    logic [31:0] b_addr [4];
    logic [31:0] b_wd   [4];

    multi_cycle_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
    multi_cycle_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

    multi_cycle_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(64), .WAIT_CYCLES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    multi_cycle_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(64), .WAIT_CYCLES(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus0.req_valid = v; bus0.req_write = w; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_write = w; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    task automatic sample(input bit sel, output logic rv, output logic rr, output logic re,
                          output logic bsy, output logic [31:0] rd);
        rv  = sel ? bus0.rsp_valid : bus2.rsp_valid;
        rr  = sel ? bus0.req_ready : bus2.req_ready;
        re  = sel ? bus0.rsp_error : bus2.rsp_error;
        bsy = sel ? bus0.busy      : bus2.busy;
        rd  = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
    endtask

    task automatic push_exp(input bit sel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd);
        exp_t        e;
        logic [63:0] wi;
        logic [5:0]  idx;
        logic        err;
        err     = addr_error(64'(addr), 6);
        wi      = word_index(64'(addr));
        idx     = wi[5:0];
        e.error = err;
        e.rdata = (err || wr) ? 32'd0 : model_mem[sel][idx];
        if (!err && wr) model_mem[sel][idx] = wd;
        sb_q.push_back(e);
    endtask

    task automatic compare_pop(input string tag, input logic [31:0] rd, input logic re);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_rdata"}, rd, e.rdata);
            check({tag, "_error"}, 32'(re), 32'(e.error));
        end
    endtask

    // Single transaction; latency counted in edges from the edge the request was driven after.
    task automatic do_txn(input bit sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        logic rv, rr, re, bsy;
        logic [31:0] rd;
        int edges;
        push_exp(sel, wr, addr, wd);
        @(posedge clk); #1 drive(sel, 1'b1, wr, addr, wd);
        @(posedge clk); edges = 1;
        #1 drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        rv = 1'b0;
        while (edges < 50) begin
            @(negedge clk);
            sample(sel, rv, rr, re, bsy, rd);
            if (rv) break;
            @(posedge clk); edges++;
        end
        check({tag, "_timeout"}, 32'(rv), 32'd1);
        check({tag, "_latency"}, 32'(edges), sel ? 32'd1 : 32'd3);
        compare_pop(tag, rd, re);
        check({tag, "_ready_in_rsp"}, 32'(rr), 32'd0);
        check({tag, "_busy_in_rsp"}, 32'(bsy), 32'd1);
        $display("txn %s sel=%0d wr=%0d addr=%h rdata=%h err=%0d lat=%0d", tag, sel, wr, addr, rd, re, edges);
        @(posedge clk); @(negedge clk);
        sample(sel, rv, rr, re, bsy, rd);
        check({tag, "_pulse_end"}, 32'(rv), 32'd0);
        check({tag, "_rdata_clear"}, rd, 32'd0);
    endtask

    // Requester holds req_valid high, advancing the request after each acceptance.
    task automatic burst(input bit sel, input int n, input int gap, input string tag);
        logic rv, rr, re, bsy;
        logic [31:0] rd;
        int acc, pulses, last_pulse, cyc;
        bit do_acc;
        for (int i = 0; i < n; i++) push_exp(sel, b_wr[i], b_addr[i], b_wd[i]);
        acc = 0; pulses = 0; last_pulse = -1; cyc = 0;
        @(posedge clk); #1 drive(sel, 1'b1, b_wr[0], b_addr[0], b_wd[0]);
        while (pulses < n && cyc < 100) begin
            @(negedge clk); cyc++;
            sample(sel, rv, rr, re, bsy, rd);
            if (rv) begin
                compare_pop(tag, rd, re);
                check({tag, "_ready_in_rsp"}, 32'(rr), 32'd0);
                if (last_pulse >= 0) check({tag, "_spacing"}, 32'(cyc - last_pulse), 32'(gap));
                $display("burst %s pulse=%0d cycle=%0d rdata=%h err=%0d", tag, pulses, cyc, rd, re);
                last_pulse = cyc;
                pulses++;
            end
            do_acc = rr && (sel ? bus0.req_valid : bus2.req_valid);
            @(posedge clk); #1;
            if (do_acc) begin
                acc++;
                if (acc < n) drive(sel, 1'b1, b_wr[acc], b_addr[acc], b_wd[acc]);
                else drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        check({tag, "_pulse_count"}, 32'(pulses), 32'(n));
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic rv, rr, re, bsy;
        logic [31:0] rd;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) model_mem[s][i] = 32'd0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample(1'b0, rv, rr, re, bsy, rd);
        check("rst_ready", 32'(rr), 32'd1);
        check("rst_rsp_valid", 32'(rv), 32'd0);
        check("rst_busy", 32'(bsy), 32'd0);
        check("rst_rdata", rd, 32'd0);
        check("rst_error", 32'(re), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, "rd_10");
        do_txn(1'b0, 1'b1, 32'h12, 32'h12345678, "wr_misaligned");
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, "rd_10_again");
        do_txn(1'b0, 1'b0, 32'h100, 32'h0, "rd_out_of_range");
        do_txn(1'b0, 1'b1, 32'h8, 32'h08080808, "wr_08");
        do_txn(1'b0, 1'b1, 32'hFC, 32'hA5A5A5A5, "wr_top_word");
        do_txn(1'b0, 1'b0, 32'hFC, 32'h0, "rd_top_word");

        b_wr[0] = 1'b0; b_addr[0] = 32'h0; b_wd[0] = 32'h0;
        b_wr[1] = 1'b0; b_addr[1] = 32'h4; b_wd[1] = 32'h0;
        b_wr[2] = 1'b0; b_addr[2] = 32'h8; b_wd[2] = 32'h0;
        burst(1'b0, 3, 4, "held_reads");

        // Store abandoned by reset one cycle after acceptance.
        @(posedge clk); #1 drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        sample(1'b0, rv, rr, re, bsy, rd);
        check("abort_busy", 32'(bsy), 32'd0);
        check("abort_ready", 32'(rr), 32'd1);
        check("abort_rsp_valid", 32'(rv), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample(1'b0, rv, rr, re, bsy, rd);
            check("abort_no_pulse", 32'(rv), 32'd0);
        end
        $display("txn abort_store addr=00000020 busy=%0d ready=%0d", bsy, rr);
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, "rd_20_after_abort");

        do_txn(1'b1, 1'b0, 32'h0, 32'h0, "w0_rd_00");
        b_wr[0] = 1'b1; b_addr[0] = 32'h4; b_wd[0] = 32'h11111111;
        b_wr[1] = 1'b0; b_addr[1] = 32'h4; b_wd[1] = 32'h0;
        b_wr[2] = 1'b1; b_addr[2] = 32'h4; b_wd[2] = 32'h22222222;
        b_wr[3] = 1'b0; b_addr[3] = 32'h4; b_wd[3] = 32'h0;
        burst(1'b1, 4, 2, "w0_alt_wr_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
